vga_timgen: RTL and testbench

Raster timing generator for the VGA/LCD controller. It runs a horizontal and a vertical timing FSM from the CTRL/HVVL/HTIM/VTIM register fields and produces sync, blanking and data-enable strobes plus pixel coordinates. Downstream, the pixel fetch/format stage consumes the coordinates and `de_o`. The status logic consumes the line-end and frame-end pulses to set HIF and VIF.

---
 rtl/vga_timgen_pkg.sv | 43 ++++
 rtl/vga_timaxis.sv | 78 +++++++
 rtl/vga_timgen.sv | 158 +++++++++++++++
 tb/tb_vga_timgen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timgen_pkg.sv
// Shared definitions for the VGA raster timing generator: widths, axis FSM
// encodings and the shadowed timing configuration record.
package vga_timgen_pkg;

    localparam int VGA_TIMCNT_WIDTH = 12;  // internal counter / coordinate width
    localparam int VGA_TB_WIDTH     = 10;  // porch and sync size fields
    localparam int VGA_VB_WIDTH     = 16;  // visible length fields

    typedef enum logic [1:0] {
        VGA_TIMFSM_VISIBLE    = 2'd0,
        VGA_TIMFSM_FRONTPORCH = 2'd1,
        VGA_TIMFSM_SYNC       = 2'd2,
        VGA_TIMFSM_BACKPORCH  = 2'd3
    } vga_timfsm_e;

    typedef struct packed {
        logic [VGA_VB_WIDTH-1:0] hvlen;
        logic [VGA_VB_WIDTH-1:0] vvlen;
        logic [VGA_TB_WIDTH-1:0] hfp;
        logic [VGA_TB_WIDTH-1:0] hsn;
        logic [VGA_TB_WIDTH-1:0] hbp;
        logic [VGA_TB_WIDTH-1:0] vfp;
        logic [VGA_TB_WIDTH-1:0] vsn;
        logic [VGA_TB_WIDTH-1:0] vbp;
        logic                    hspol;
        logic                    vspol;
        logic                    blpol;
    } vga_timcfg_t;

    function automatic vga_timfsm_e vga_timfsm_next(input vga_timfsm_e s);
        vga_timfsm_e n;
        n = VGA_TIMFSM_VISIBLE;
        case (s)
            VGA_TIMFSM_VISIBLE:    n = VGA_TIMFSM_FRONTPORCH;
            VGA_TIMFSM_FRONTPORCH: n = VGA_TIMFSM_SYNC;
            VGA_TIMFSM_SYNC:       n = VGA_TIMFSM_BACKPORCH;
            VGA_TIMFSM_BACKPORCH:  n = VGA_TIMFSM_VISIBLE;
            default:               n = VGA_TIMFSM_VISIBLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_timaxis.sv
// One raster axis: VISIBLE/FRONTPORCH/SYNC/BACKPORCH FSM with a per-state unit
// counter. state_o/cnt_o give the position that will be in force after this clk.
module vga_timaxis
    import vga_timgen_pkg::*;
#(
    parameter int CNT_WIDTH = VGA_TIMCNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    adv_i,
    input  logic [VGA_VB_WIDTH-1:0] vlen_i,
    input  logic [VGA_TB_WIDTH-1:0] fp_i,
    input  logic [VGA_TB_WIDTH-1:0] sn_i,
    input  logic [VGA_TB_WIDTH-1:0] bp_i,
    output vga_timfsm_e             state_o,
    output logic [CNT_WIDTH-1:0]    cnt_o,
    output logic                    last_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    vga_timfsm_e          state_q;
    vga_timfsm_e          state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] size;
    logic [CNT_WIDTH-1:0] last_cnt;
    logic                 unit_last;
    logic                 unused_vlen;

    // Visible length is deliberately truncated to the counter width.
    assign unused_vlen = ^vlen_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        size      = CNT_WIDTH'(vlen_i);
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            VGA_TIMFSM_VISIBLE:    size = CNT_WIDTH'(vlen_i);
            VGA_TIMFSM_FRONTPORCH: size = CNT_WIDTH'(fp_i);
            VGA_TIMFSM_SYNC:       size = CNT_WIDTH'(sn_i);
            VGA_TIMFSM_BACKPORCH:  size = CNT_WIDTH'(bp_i);
            default:               size = CNT_WIDTH'(vlen_i);
        endcase
        last_cnt  = (size == '0) ? '0 : size - CNT_ONE;
        unit_last = (cnt_q == last_cnt);

        if (clr_i) begin
            state_d = VGA_TIMFSM_VISIBLE;
            cnt_d   = '0;
        end else if (adv_i) begin
            if (unit_last) begin
                state_d = vga_timfsm_next(state_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst_n_i) begin
            state_q <= VGA_TIMFSM_VISIBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_o  = (state_q == VGA_TIMFSM_BACKPORCH) && unit_last;
    assign state_o = state_d;
    assign cnt_o   = cnt_d;

endmodule

// File: rtl/vga_timgen.sv
// VGA raster timing generator: shadowed timing config, H and V axis FSMs,
// registered sync/blank/de/coordinate outputs and line/frame end pulses.
module vga_timgen
    import vga_timgen_pkg::*;
#(
    parameter int CNT_WIDTH = VGA_TIMCNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    pclk_en_i,
    input  logic                    hspol_i,
    input  logic                    vspol_i,
    input  logic                    blpol_i,
    input  logic [VGA_VB_WIDTH-1:0] hvlen_i,
    input  logic [VGA_VB_WIDTH-1:0] vvlen_i,
    input  logic [VGA_TB_WIDTH-1:0] hfp_i,
    input  logic [VGA_TB_WIDTH-1:0] hsn_i,
    input  logic [VGA_TB_WIDTH-1:0] hbp_i,
    input  logic [VGA_TB_WIDTH-1:0] vfp_i,
    input  logic [VGA_TB_WIDTH-1:0] vsn_i,
    input  logic [VGA_TB_WIDTH-1:0] vbp_i,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    blank_o,
    output logic                    de_o,
    output logic [CNT_WIDTH-1:0]    pix_x_o,
    output logic [CNT_WIDTH-1:0]    pix_y_o,
    output logic                    hend_o,
    output logic                    vend_o
);

    vga_timcfg_t          live_cfg;
    vga_timcfg_t          shadow_q;
    vga_timcfg_t          shadow_d;
    logic                 active_q;
    logic                 active_d;

    logic                 h_adv;
    logic                 h_last;
    logic                 v_last;
    logic                 line_end;
    logic                 frame_end;
    vga_timfsm_e          h_state_nxt;
    vga_timfsm_e          v_state_nxt;
    logic [CNT_WIDTH-1:0] h_cnt_nxt;
    logic [CNT_WIDTH-1:0] v_cnt_nxt;

    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 blank_q, blank_d;
    logic                 de_q, de_d;
    logic [CNT_WIDTH-1:0] pix_x_q, pix_x_d;
    logic [CNT_WIDTH-1:0] pix_y_q, pix_y_d;
    logic                 hend_q, hend_d;
    logic                 vend_q, vend_d;

    assign live_cfg = '{
        hvlen: hvlen_i, vvlen: vvlen_i,
        hfp:   hfp_i,   hsn:   hsn_i,   hbp: hbp_i,
        vfp:   vfp_i,   vsn:   vsn_i,   vbp: vbp_i,
        hspol: hspol_i, vspol: vspol_i, blpol: blpol_i
    };

    // The enabling clk only loads the shadow; ticks count from the next clk on.
    assign active_d  = en_i;
    assign h_adv     = active_q & en_i & pclk_en_i;
    assign line_end  = h_adv & h_last;
    assign frame_end = line_end & v_last;

    vga_timaxis #(.CNT_WIDTH(CNT_WIDTH)) u_haxis (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~en_i),
        .adv_i   (h_adv),
        .vlen_i  (shadow_q.hvlen),
        .fp_i    (shadow_q.hfp),
        .sn_i    (shadow_q.hsn),
        .bp_i    (shadow_q.hbp),
        .state_o (h_state_nxt),
        .cnt_o   (h_cnt_nxt),
        .last_o  (h_last)
    );

    vga_timaxis #(.CNT_WIDTH(CNT_WIDTH)) u_vaxis (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~en_i),
        .adv_i   (line_end),
        .vlen_i  (shadow_q.vvlen),
        .fp_i    (shadow_q.vfp),
        .sn_i    (shadow_q.vsn),
        .bp_i    (shadow_q.vbp),
        .state_o (v_state_nxt),
        .cnt_o   (v_cnt_nxt),
        .last_o  (v_last)
    );

    always_comb begin
        shadow_d = shadow_q;
        if ((en_i && !active_q) || frame_end) begin
            shadow_d = live_cfg;
        end

        de_d    = en_i && (h_state_nxt == VGA_TIMFSM_VISIBLE)
                       && (v_state_nxt == VGA_TIMFSM_VISIBLE);
        pix_x_d = de_d ? h_cnt_nxt : '0;
        pix_y_d = de_d ? v_cnt_nxt : '0;
        hend_d  = line_end;
        vend_d  = frame_end;

        // Idle levels follow the live polarity inputs, not the shadow.
        hsync_d = hspol_i;
        vsync_d = vspol_i;
        blank_d = ~blpol_i;
        if (en_i) begin
            hsync_d = (h_state_nxt == VGA_TIMFSM_SYNC) ^ shadow_d.hspol;
            vsync_d = (v_state_nxt == VGA_TIMFSM_SYNC) ^ shadow_d.vspol;
            blank_d = ~de_d ^ shadow_d.blpol;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            shadow_q <= '0;
            hsync_q  <= hspol_i;
            vsync_q  <= vspol_i;
            blank_q  <= ~blpol_i;
            de_q     <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            hend_q   <= 1'b0;
            vend_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            de_q     <= de_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
            hend_q   <= hend_d;
            vend_q   <= vend_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign blank_o = blank_q;
    assign de_o    = de_q;
    assign pix_x_o = pix_x_q;
    assign pix_y_o = pix_y_q;
    assign hend_o  = hend_q;
    assign vend_o  = vend_q;

endmodule

// File: tb/tb_vga_timgen.sv
// Self-checking bench for vga_timgen: a tick-index raster model checked every
// cycle, plus directed scenarios with hand-computed durations.
module tb_vga_timgen;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n, en, pclk_en, hspol, vspol, blpol;
    logic [15:0]   hvlen, vvlen;
    logic [9:0]    hfp, hsn, hbp, vfp, vsn, vbp;
    logic          hsync_o, vsync_o, blank_o, de_o, hend_o, vend_o;
    logic [CW-1:0] pix_x_o, pix_y_o;

    always #5 clk = ~clk;

    vga_timgen #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pclk_en_i(pclk_en),
        .hspol_i(hspol), .vspol_i(vspol), .blpol_i(blpol),
        .hvlen_i(hvlen), .vvlen_i(vvlen),
        .hfp_i(hfp), .hsn_i(hsn), .hbp_i(hbp),
        .vfp_i(vfp), .vsn_i(vsn), .vbp_i(vbp),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o), .de_o(de_o),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .hend_o(hend_o), .vend_o(vend_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int div      = 1;
    bit chk_on   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: position = tick index within frame
    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp, bp;
    } cfg_t;

    cfg_t m_cfg;
    bit   m_active = 0;
    int   m_t = 0;
    bit   e_hs, e_vs, e_bl, e_de, e_hend, e_vend;
    int   e_x, e_y;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int line_len(input cfg_t c);
        return eff(c.hv % 4096) + eff(c.hf) + eff(c.hs) + eff(c.hb);
    endfunction

    function automatic int frame_lines(input cfg_t c);
        return eff(c.vv % 4096) + eff(c.vf) + eff(c.vs) + eff(c.vb);
    endfunction

    // 0 visible, 1 front porch, 2 sync, 3 back porch
    function automatic int region(input int pos, input int vis, input int fp, input int sn);
        if (pos < vis) return 0;
        if (pos < vis + fp) return 1;
        if (pos < vis + fp + sn) return 2;
        return 3;
    endfunction

    function automatic cfg_t live();
        cfg_t c;
        c.hv = hvlen; c.hf = hfp; c.hs = hsn; c.hb = hbp;
        c.vv = vvlen; c.vf = vfp; c.vs = vsn; c.vb = vbp;
        c.hp = hspol; c.vp = vspol; c.bp = blpol;
        return c;
    endfunction

    always @(posedge clk) begin
        int l, f, x, y, hr, vr;
        e_hend = 0;
        e_vend = 0;
        if (!rst_n || !en) begin
            m_active = 0;
            m_t  = 0;
            e_hs = hspol; e_vs = vspol; e_bl = !blpol;
            e_de = 0; e_x = 0; e_y = 0;
        end else begin
            if (!m_active) begin
                m_cfg = live();
                m_active = 1;
                m_t = 0;
            end else if (pclk_en) begin
                l = line_len(m_cfg);
                f = frame_lines(m_cfg);
                m_t++;
                if (m_t % l == 0) e_hend = 1;
                if (m_t == l * f) begin
                    e_vend = 1;
                    m_t = 0;
                    m_cfg = live();
                end
            end
            l  = line_len(m_cfg);
            x  = m_t % l;
            y  = m_t / l;
            hr = region(x, eff(m_cfg.hv % 4096), eff(m_cfg.hf), eff(m_cfg.hs));
            vr = region(y, eff(m_cfg.vv % 4096), eff(m_cfg.vf), eff(m_cfg.vs));
            e_de = (hr == 0) && (vr == 0);
            e_x  = e_de ? x : 0;
            e_y  = e_de ? y : 0;
            e_hs = (hr == 2) ^ m_cfg.hp;
            e_vs = (vr == 2) ^ m_cfg.vp;
            e_bl = !e_de ^ m_cfg.bp;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [11:0] ex, ey;
        if (chk_on) begin
            check("sync_blank_de_pulses",
                  {26'd0, hsync_o, vsync_o, blank_o, de_o, hend_o, vend_o},
                  {26'd0, e_hs, e_vs, e_bl, e_de, e_hend, e_vend});
            if (e_de) begin
                ex = e_x[11:0];
                ey = e_y[11:0];
                check("pix_xy", {8'd0, pix_x_o, pix_y_o}, {8'd0, ex, ey});
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        pclk_en = (div == 1) || (cyc % div == 0);
    endtask

    task automatic wait_pulse(input bit is_vend, output bit ok);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (is_vend ? vend_o : hend_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic hend_interval(input string name, input int exp);
        bit ok;
        int n;
        wait_pulse(0, ok);
        if (!ok) begin
            check({name, "_timeout"}, 0, 1);
            return;
        end
        n = 0;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            n++;
            if (hend_o) begin
                ok = 1;
                break;
            end
        end
        check(name, ok ? n : -1, exp);
    endtask

    task automatic wait_pixel(input string name, input int px, input int py);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (de_o && pix_x_o == CW'(px) && pix_y_o == CW'(py)) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // One whole frame of the small raster, starting at a vend_o cycle.
    task automatic frame_window(input string name, input int d, input bit inv);
        bit ok;
        int de_n = 0, hs_n = 0, vs_n = 0, he_n = 0, ve_n = 0, eq_n = 0;
        logic [7:0] hs_first = '0;
        wait_pulse(1, ok);
        if (!ok) begin
            check({name, "_vend_timeout"}, 0, 1);
            return;
        end
        for (int i = 0; i < 48 * d; i++) begin
            de_n += de_o;
            hs_n += hsync_o ^ hspol;
            vs_n += vsync_o ^ vspol;
            he_n += hend_o;
            ve_n += vend_o;
            eq_n += (blank_o == de_o);
            if (i < 8) hs_first[i] = hsync_o ^ hspol;
            step();
        end
        check({name, "_de_clks"},    de_n, 12 * d);
        check({name, "_hsync_clks"}, hs_n, 12 * d);
        check({name, "_vsync_clks"}, vs_n, 8 * d);
        check({name, "_hend_clks"},  he_n, 6);
        check({name, "_vend_clks"},  ve_n, 1);
        check({name, "_vend_period"}, vend_o, 1);
        check({name, "_blank_eq_de"}, eq_n, inv ? 48 * d : 0);
        if (d == 1) check({name, "_hsync_line0"}, hs_first, 8'b0110_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; en = 1; pclk_en = 1;
        hspol = 0; vspol = 0; blpol = 0;
        hvlen = 4; hfp = 1; hsn = 2; hbp = 1;
        vvlen = 3; vfp = 1; vsn = 1; vbp = 1;

        step();
        chk_on = 1;
        step();
        check("reset_de",    de_o, 0);
        check("reset_hsync", hsync_o, 0);
        check("reset_blank", blank_o, 1);
        check("reset_hend",  hend_o, 0);
        rst_n = 1;

        // Small raster, one pixel per clk
        frame_window("div1", 1, 0);

        // Reset mid-frame
        repeat (10) step();
        rst_n = 0;
        step();
        check("rst_mid_de",   de_o, 0);
        check("rst_mid_vend", vend_o, 0);
        rst_n = 1;

        // Pixel tick every 3rd clk
        div = 3;
        frame_window("div3", 3, 0);
        div = 1;

        // Inverted polarities, idle levels first
        en = 0;
        hspol = 1; vspol = 1; blpol = 1;
        step();
        check("inv_idle_hsync", hsync_o, 1);
        check("inv_idle_vsync", vsync_o, 1);
        check("inv_idle_blank", blank_o, 0);
        en = 1;
        frame_window("inv", 1, 1);

        // Mid-frame length change takes effect from the next frame
        en = 0;
        hspol = 0; vspol = 0; blpol = 0;
        step();
        en = 1;
        wait_pixel("find_pix_1_1", 1, 1);
        hvlen = 6;
        hend_interval("line_old_len", 8);
        begin
            bit ok;
            wait_pulse(1, ok);
            check("shadow_vend_seen", ok, 1);
        end
        hend_interval("line_new_len", 10);

        // Enable dropped at pixel (2,0), re-raised 5 clk later
        wait_pixel("find_pix_2_0", 2, 0);
        en = 0;
        step();
        check("drop_de",    de_o, 0);
        check("drop_hend",  hend_o, 0);
        check("drop_vend",  vend_o, 0);
        check("drop_hsync", hsync_o, 0);
        repeat (4) step();
        en = 1;
        step();
        check("restart_de", de_o, 1);
        check("restart_x",  pix_x_o, 0);
        check("restart_y",  pix_y_o, 0);

        // Zero-size porches last one tick
        en = 0;
        hvlen = 4; hfp = 0; hsn = 2; hbp = 0;
        step();
        en = 1;
        hend_interval("zero_porch_line", 8);

        repeat (5) step();
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
